// File: rtl/dm_pkg.sv
// Shared types for the data-memory arbiter: FSM state and access-size encodings.
package dm_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;
endpackage

// File: rtl/dm_lane.sv
// Byte-lane datapath: write enables, write replication, load extraction/extension
// and misalignment detection for one latched access.
module dm_lane
  import dm_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_uns,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdword,
  output logic [3:0]  o_be,
  output logic [31:0] o_din,
  output logic [31:0] o_rdata,
  output logic        o_misal
);
  logic [31:0] w_shift;

  // Bring the addressed byte/half down to bit 0 before truncation.
  assign w_shift = i_rdword >> {i_off, 3'b000};

  always_comb begin
    o_be    = 4'b0000;
    o_din   = i_wdata;
    o_rdata = 32'h0;
    o_misal = 1'b0;
    case (i_size)
      SZ_B: begin
        o_be    = 4'b0001 << i_off;
        o_din   = {4{i_wdata[7:0]}};
        o_rdata = i_uns ? {24'h0, w_shift[7:0]} : {{24{w_shift[7]}}, w_shift[7:0]};
      end
      SZ_H: begin
        o_be    = 4'b0011 << i_off;
        o_din   = {2{i_wdata[15:0]}};
        o_rdata = i_uns ? {16'h0, w_shift[15:0]} : {{16{w_shift[15]}}, w_shift[15:0]};
        o_misal = i_off[0];
      end
      SZ_W: begin
        o_be    = 4'b1111;
        o_rdata = w_shift;
        o_misal = (i_off != 2'b00);
      end
      default: o_misal = 1'b1;
    endcase
  end
endmodule

// File: rtl/dm_arb_ctrl.sv
// Two-requester round-robin arbiter in front of a single-port data memory;
// one access per three cycles (IDLE latch, ACCESS memory cycle, RESP completion).
module dm_arb_ctrl
  import dm_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW+1:0] m0_addr,
  input  logic [1:0]    m0_size,
  input  logic          m0_uns,
  input  logic [31:0]   m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [31:0]   m0_rdata,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW+1:0] m1_addr,
  input  logic [1:0]    m1_size,
  input  logic          m1_uns,
  input  logic [31:0]   m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [31:0]   m1_rdata,
  output logic          m1_err,
  output logic [AW-1:0] dm_addr,
  output logic [31:0]   dm_din,
  output logic [3:0]    dm_wrbe,
  output logic          dm_wr,
  input  logic [31:0]   dm_dout
);
  state_t        r_state, w_state_next;
  logic          r_sel, r_last, r_we, r_uns, r_err;
  logic [AW+1:0] r_addr;
  logic [1:0]    r_size;
  logic [31:0]   r_wdata, r_rdata;

  logic          w_win, w_access, w_resp, w_misal;
  logic [3:0]    w_be;
  logic [31:0]   w_din, w_lane_rdata;

  // Contention goes to whoever was not granted last; r_last resets to 1 so m0 wins first.
  assign w_win    = (m0_req && m1_req) ? ~r_last : m1_req;
  assign w_access = (r_state == ST_ACCESS);
  assign w_resp   = (r_state == ST_RESP);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (m0_req || m1_req) w_state_next = ST_ACCESS;
      ST_ACCESS: w_state_next = ST_RESP;
      ST_RESP:   w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sel   <= 1'b0;
      r_last  <= 1'b1;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_addr  <= '0;
      r_size  <= SZ_B;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_IDLE && (m0_req || m1_req)) begin
        r_sel   <= w_win;
        r_last  <= w_win;
        r_we    <= w_win ? m1_we    : m0_we;
        r_uns   <= w_win ? m1_uns   : m0_uns;
        r_addr  <= w_win ? m1_addr  : m0_addr;
        r_size  <= w_win ? m1_size  : m0_size;
        r_wdata <= w_win ? m1_wdata : m0_wdata;
      end
      if (w_access) begin
        r_rdata <= (w_misal || r_we) ? 32'h0 : w_lane_rdata;
        r_err   <= w_misal;
      end
    end
  end

  dm_lane u_lane (
    .i_off   (r_addr[1:0]),
    .i_size  (r_size),
    .i_uns   (r_uns),
    .i_wdata (r_wdata),
    .i_rdword(dm_dout),
    .o_be    (w_be),
    .o_din   (w_din),
    .o_rdata (w_lane_rdata),
    .o_misal (w_misal)
  );

  assign dm_addr = w_access ? r_addr[AW+1:2] : '0;
  assign dm_wr   = w_access && r_we && !w_misal;
  assign dm_wrbe = dm_wr ? w_be : 4'b0000;
  assign dm_din  = w_access ? w_din : 32'h0;

  assign m0_gnt    = w_access && !r_sel;
  assign m1_gnt    = w_access &&  r_sel;
  assign m0_rvalid = w_resp && !r_sel;
  assign m1_rvalid = w_resp &&  r_sel;
  assign m0_rdata  = m0_rvalid ? r_rdata : 32'h0;
  assign m1_rdata  = m1_rvalid ? r_rdata : 32'h0;
  assign m0_err    = m0_rvalid && r_err;
  assign m1_err    = m1_rvalid && r_err;
endmodule

// File: tb/tb_dm_arb_ctrl.sv
// Self-checking bench for dm_arb_ctrl: directed scenarios, reset abort, round-robin
// and random accesses checked against a byte-level reference memory.
module tb_dm_arb_ctrl;
  localparam int AW = 10;
  localparam int BW = AW + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m0_uns, m1_req, m1_we, m1_uns;
  logic [BW-1:0] m0_addr, m1_addr;
  logic [1:0]    m0_size, m1_size;
  logic [31:0]   m0_wdata, m1_wdata;
  logic          m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0]   m0_rdata, m1_rdata;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_din, dm_dout;
  logic [3:0]    dm_wrbe;
  logic          dm_wr;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_last = 1;

  always #5 clk = ~clk;

  dm_arb_ctrl #(.AW(AW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_size(m0_size),
    .m0_uns(m0_uns), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_size(m1_size),
    .m1_uns(m1_uns), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_wrbe(dm_wrbe), .dm_wr(dm_wr),
    .dm_dout(dm_dout)
  );

  // Memory model attached to the DUT (environment, not reference).
  logic [31:0] mem [0:(1<<AW)-1];
  logic        mem_ready = 1'b0;
  logic [7:0]  ref_mem [0:(1<<BW)-1];

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (dm_wr) begin
      for (int l = 0; l < 4; l++)
        if (dm_wrbe[l]) mem[dm_addr][8*l +: 8] <= dm_din[8*l +: 8];
    end
  end
  assign dm_dout = mem[dm_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: accesses as sequences of bytes in a byte-addressed array.
  function automatic int nbytes(logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit is_legal(logic [1:0] sz, logic [BW-1:0] a);
    return (sz != 2'b11) && ((int'(a) % nbytes(sz)) == 0);
  endfunction

  function automatic logic [31:0] ref_load(logic [BW-1:0] a, logic [1:0] sz, logic u);
    logic [31:0] v = 32'h0;
    logic [31:0] ones = 32'hFFFF_FFFF;
    int n = nbytes(sz);
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(a) + i]) << (8 * i));
    if (n < 4 && !u && v[8*n-1]) v = v | (ones << (8 * n));
    return v;
  endfunction

  task automatic drive(input int p, input logic req, input logic we, input logic [BW-1:0] a,
                       input logic [1:0] sz, input logic u, input logic [31:0] wd);
    if (p == 0) begin
      m0_req = req; m0_we = we; m0_addr = a; m0_size = sz; m0_uns = u; m0_wdata = wd;
    end else begin
      m1_req = req; m1_we = we; m1_addr = a; m1_size = sz; m1_uns = u; m1_wdata = wd;
    end
  endtask

  task automatic access(input int p, input logic we, input logic [BW-1:0] a, input logic [1:0] sz,
                        input logic u, input logic [31:0] wd, output logic [31:0] rd_o);
    int          n = nbytes(sz);
    bit          legal = is_legal(sz, a);
    logic        exp_wr = we && legal;
    logic [31:0] exp_rd = (!legal || we) ? 32'h0 : ref_load(a, sz, u);
    logic [3:0]  exp_be = 4'b0000;
    logic [31:0] exp_din = 32'h0;
    int          cyc = 0;
    for (int i = 0; i < n && i < 4; i++) exp_be[(int'(a[1:0]) + i) % 4] = 1'b1;
    for (int l = 0; l < 4; l++) exp_din[8*l +: 8] = wd[8*(l % n) +: 8];

    drive(p, 1'b1, we, a, sz, u, wd);
    do begin
      @(posedge clk); #1; cyc++;
    end while (!(p == 1 ? m1_gnt : m0_gnt) && cyc < 4);
    chk("gnt", p == 1 ? m1_gnt : m0_gnt, 1);
    chk("gnt_latency", cyc, 1);
    chk("gnt_other", p == 1 ? m0_gnt : m1_gnt, 0);
    chk("dm_addr", dm_addr, 32'(a[BW-1:2]));
    chk("dm_wr", dm_wr, exp_wr);
    chk("dm_wrbe", dm_wrbe, exp_wr ? exp_be : 4'b0000);
    if (exp_wr) chk("dm_din", dm_din, exp_din);
    drive(p, 1'b0, we, a, sz, u, wd);

    @(posedge clk); #1;
    chk("rvalid", p == 1 ? m1_rvalid : m0_rvalid, 1);
    chk("rdata", p == 1 ? m1_rdata : m0_rdata, exp_rd);
    chk("err", p == 1 ? m1_err : m0_err, !legal);
    chk("rvalid_other", p == 1 ? m0_rvalid : m1_rvalid, 0);
    chk("rdata_other", p == 1 ? m0_rdata : m1_rdata, 0);
    chk("dm_wr_resp", dm_wr, 0);
    rd_o = p == 1 ? m1_rdata : m0_rdata;
    if (exp_wr) for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
    exp_last = p;
    $display("txn m%0d we=%0d addr=%03h size=%0d uns=%0d wdata=%08h rdata=%08h exp=%08h err=%0d",
             p, we, a, sz, u, wd, rd_o, exp_rd, !legal);

    @(posedge clk); #1;
    chk("rvalid_idle", p == 1 ? m1_rvalid : m0_rvalid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd, w;
    int k, exp_w;

    for (int i = 0; i < (1 << AW); i++) begin
      w = init_word(i);
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
    end
    rst = 1'b1;
    drive(0, 0, 0, '0, 2'b00, 0, 0);
    drive(1, 0, 0, '0, 2'b00, 0, 0);
    #1;
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_m1_rvalid", m1_rvalid, 0);
    chk("rst_dm_wr", dm_wr, 0);
    chk("rst_dm_addr", dm_addr, 0);
    chk("rst_dm_wrbe", dm_wrbe, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    access(0, 1, 12'h010, 2'b10, 0, 32'hDEADBEEF, rd);
    access(0, 1, 12'h020, 2'b10, 0, 32'h80FF7F01, rd);
    access(1, 0, 12'h023, 2'b00, 0, 0, rd);
    chk("load_b_sext", rd, 32'hFFFFFF80);
    access(1, 0, 12'h023, 2'b00, 1, 0, rd);
    chk("load_b_zext", rd, 32'h00000080);
    access(1, 0, 12'h022, 2'b01, 0, 0, rd);
    chk("load_h_sext", rd, 32'hFFFF80FF);
    access(0, 1, 12'h013, 2'b01, 0, 32'h00001234, rd);
    access(0, 0, 12'h010, 2'b10, 0, 0, rd);
    chk("misal_unchanged", rd, 32'hDEADBEEF);
    access(0, 0, 12'h021, 2'b11, 1, 0, rd);
    access(1, 1, 12'h005, 2'b00, 0, 32'h000000A5, rd);
    access(1, 0, 12'h004, 2'b10, 0, 0, rd);
    chk("byte_lane", 32'(rd[15:8]), 32'hA5);

    // Reset in the middle of an ACCESS cycle of a store.
    drive(0, 1, 1, 12'h030, 2'b10, 0, 32'h12345678);
    @(posedge clk); #1;
    chk("abort_gnt_pre", m0_gnt, 1);
    chk("abort_wr_pre", dm_wr, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_gnt", m0_gnt, 0);
    chk("abort_wr", dm_wr, 0);
    chk("abort_wrbe", dm_wrbe, 0);
    chk("abort_addr", dm_addr, 0);
    drive(0, 0, 1, 12'h030, 2'b10, 0, 32'h12345678);
    @(posedge clk); #1 rst = 1'b0;
    exp_last = 1;
    for (int c = 0; c < 3; c++) begin
      chk("abort_no_rvalid", m0_rvalid | m1_rvalid, 0);
      @(posedge clk); #1;
    end

    // Both requesters continuously: grants must alternate every three cycles.
    drive(0, 1, 0, 12'h020, 2'b10, 0, 0);
    drive(1, 1, 0, 12'h040, 2'b10, 0, 0);
    for (int g = 0; g < 6; g++) begin
      k = 0;
      do begin
        @(posedge clk); #1; k++;
      end while (!(m0_gnt || m1_gnt) && k < 5);
      exp_w = 1 - exp_last;
      chk("rr_one_gnt", m0_gnt ^ m1_gnt, 1);
      chk("rr_winner", m1_gnt, exp_w);
      chk("rr_period", k, (g == 0) ? 1 : 3);
      $display("txn rr grant=%0d m0_gnt=%0d m1_gnt=%0d cycles=%0d", g, m0_gnt, m1_gnt, k);
      exp_last = exp_w;
    end
    drive(0, 0, 0, 12'h020, 2'b10, 0, 0);
    drive(1, 0, 0, 12'h040, 2'b10, 0, 0);
    repeat (3) @(posedge clk);
    #1;

    access(0, 0, 12'h030, 2'b10, 0, 0, rd);

    for (int t = 0; t < 40; t++) begin
      access($urandom_range(0, 1), 1'($urandom_range(0, 1)), 12'($urandom_range(0, 255)),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
